// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared constants and types for the fpmul arbiter slice.
//   FP_W       operand / result width
//   FPMUL_LAT  default fpmul pipeline latency (mul_pushin to mul_pushout)
//   req_id_t   requester id carried through the tag pipeline
//   gnt_vec_t  one bit per requester, at most one set
//   tag_t      {valid, id} entry of the tag pipeline
package fpmul_pkg;

    localparam int unsigned FP_W      = 64;
    localparam int unsigned FPMUL_LAT = 12;

    typedef logic       req_id_t;
    typedef logic [1:0] gnt_vec_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/fpmul_rr_arb.sv
// fpmul_rr_arb: 2-way round-robin arbiter over pre-qualified eligibility bits.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   elig   eligibility mask, bit N = requester N may be granted this cycle
//   gnt    combinational one-hot (or zero) grant vector
// When both are eligible the requester not granted last wins. The last-granted
// pointer resets to 1 so requester 0 wins the first contest.
module fpmul_rr_arb
    import fpmul_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    gnt_vec_t gnt_vec;
    logic     last_q;
    logic     last_d;

    always_comb begin
        gnt_vec = 2'b00;
        last_d  = last_q;
        if (elig == 2'b11) begin
            gnt_vec = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt_vec = elig;
        end
        if (gnt_vec[0]) begin
            last_d = 1'b0;
        end else if (gnt_vec[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt = gnt_vec;

endmodule

// File: rtl/fpmul_arb.sv
// fpmul_arb: shares one pipelined fpmul between two requesters.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req0/req1               requester N presents a valid operand triple
//   a0,b0,c0 / a1,b1,c1     operand triples
//   gnt0/gnt1               combinational accept of the presented triple
//   mul_pushin              registered issue strobe to the fpmul
//   mul_a, mul_b, mul_c     registered operands to the fpmul
//   mul_pushout, mul_r      fpmul result strobe and product
//   pushout0/pushout1       registered result-valid pulse per requester
//   r0/r1                   registered result per requester
//   err                     sticky strobe/tag mismatch flag
// Optional feature: define FPMUL_ARB_CHECK_EN to build the strobe/tag mismatch
// checker; otherwise err is tied low.
// Each requester may have at most MAXOUT operations outstanding. A tag
// pipeline, LAT stages behind mul_pushin, routes each product back to the
// requester that issued it, so per-requester order equals grant order.
module fpmul_arb
    import fpmul_pkg::*;
#(
    parameter int unsigned LAT    = FPMUL_LAT,
    parameter int unsigned MAXOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic            req1,
    input  logic [FP_W-1:0] a0,
    input  logic [FP_W-1:0] b0,
    input  logic [FP_W-1:0] c0,
    input  logic [FP_W-1:0] a1,
    input  logic [FP_W-1:0] b1,
    input  logic [FP_W-1:0] c1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            mul_pushin,
    output logic [FP_W-1:0] mul_a,
    output logic [FP_W-1:0] mul_b,
    output logic [FP_W-1:0] mul_c,
    input  logic            mul_pushout,
    input  logic [FP_W-1:0] mul_r,
    output logic            pushout0,
    output logic            pushout1,
    output logic [FP_W-1:0] r0,
    output logic [FP_W-1:0] r1,
    output logic            err
);

    localparam int unsigned CW = $clog2(MAXOUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAXOUT);

    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic [1:0]    elig;
    gnt_vec_t      gnt_vec;
    req_id_t       issue_id_q;
    tag_t          tag_q [LAT];
    tag_t          tag_out;
    logic          ret0;
    logic          ret1;

    assign elig[0] = req0 && (cnt0_q < MAX_CNT);
    assign elig[1] = req1 && (cnt1_q < MAX_CNT);

    fpmul_rr_arb u_rr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig),
        .gnt   (gnt_vec)
    );

    assign gnt0 = gnt_vec[0];
    assign gnt1 = gnt_vec[1];

    // Issue register: operands hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_pushin <= 1'b0;
            issue_id_q <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_c      <= '0;
        end else begin
            mul_pushin <= gnt0 | gnt1;
            if (gnt0) begin
                issue_id_q <= 1'b0;
                mul_a      <= a0;
                mul_b      <= b0;
                mul_c      <= c0;
            end else if (gnt1) begin
                issue_id_q <= 1'b1;
                mul_a      <= a1;
                mul_b      <= b1;
                mul_c      <= c1;
            end
        end
    end

    // Tag pipeline fed from the issue register so its output lines up with
    // mul_pushout exactly LAT cycles after mul_pushin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '{default: '0};
            end
        end else begin
            tag_q[0] <= '{valid: mul_pushin, id: issue_id_q};
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[LAT-1];
    assign ret0    = mul_pushout && tag_out.valid && (tag_out.id == 1'b0);
    assign ret1    = mul_pushout && tag_out.valid && (tag_out.id == 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pushout0 <= 1'b0;
            pushout1 <= 1'b0;
            r0       <= '0;
            r1       <= '0;
        end else begin
            pushout0 <= ret0;
            pushout1 <= ret1;
            if (ret0) begin
                r0 <= mul_r;
            end
            if (ret1) begin
                r1 <= mul_r;
            end
        end
    end

    // Outstanding counters; a grant and a return in the same cycle cancel.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        case ({gnt0, ret0})
            2'b10:   cnt0_d = cnt0_q + CW'(1);
            2'b01:   cnt0_d = cnt0_q - CW'(1);
            default: cnt0_d = cnt0_q;
        endcase
        case ({gnt1, ret1})
            2'b10:   cnt1_d = cnt1_q + CW'(1);
            2'b01:   cnt1_d = cnt1_q - CW'(1);
            default: cnt1_d = cnt1_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

`ifdef FPMUL_ARB_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (mul_pushout != tag_out.valid) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fpmul_arb.sv
// tb_fpmul_arb: directed self-checking bench for fpmul_arb with a behavioural
// LAT-deep fpmul model (r = a * b) on the fpmul side.
module tb_fpmul_arb;

    localparam int unsigned LAT    = 12;
    localparam int unsigned MAXOUT = 8;

    localparam logic [63:0] F1P0 = 64'h3FF0000000000000;
    localparam logic [63:0] F1P5 = 64'h3FF8000000000000;
    localparam logic [63:0] F2P0 = 64'h4000000000000000;
    localparam logic [63:0] F3P0 = 64'h4008000000000000;
    localparam logic [63:0] F6P0 = 64'h4018000000000000;

`ifdef FPMUL_ARB_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [63:0] a0, b0, c0, a1, b1, c1;
    logic        gnt0, gnt1;
    logic        mul_pushin;
    logic [63:0] mul_a, mul_b, mul_c;
    logic        mul_pushout;
    logic [63:0] mul_r;
    logic        pushout0, pushout1;
    logic [63:0] r0, r1;
    logic        err;
    logic        force_po;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fpmul_arb #(
        .LAT    (LAT),
        .MAXOUT (MAXOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .a0          (a0),
        .b0          (b0),
        .c0          (c0),
        .a1          (a1),
        .b1          (b1),
        .c1          (c1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .mul_pushin  (mul_pushin),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_c       (mul_c),
        .mul_pushout (mul_pushout),
        .mul_r       (mul_r),
        .pushout0    (pushout0),
        .pushout1    (pushout1),
        .r0          (r0),
        .r1          (r1),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // fpmul model: no reset, like the real pipeline.
    bit          pv [LAT];
    logic [63:0] pr [LAT];

    always @(posedge clk) begin
        pv[0] <= mul_pushin;
        pr[0] <= $realtobits($bitstoreal(mul_a) * $bitstoreal(mul_b));
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pr[i] <= pr[i-1];
        end
    end

    assign mul_pushout = pv[LAT-1] | force_po;
    assign mul_r       = pr[LAT-1];

    // Result and grant logs, sampled away from the active edge.
    logic [64:0] ret_log [$];
    int          ret_cyc [$];
    int          gnt_log [$];

    always @(negedge clk) begin
        if (pushout0) begin
            ret_log.push_back({1'b0, r0});
            ret_cyc.push_back(cyc);
        end
        if (pushout1) begin
            ret_log.push_back({1'b1, r1});
            ret_cyc.push_back(cyc);
        end
        if (gnt0) gnt_log.push_back(0);
        if (gnt1) gnt_log.push_back(1);
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        force_po = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        ret_log.delete();
        ret_cyc.delete();
        gnt_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          g;
        int          n0;
        int          first_po;
        logic        gnt0_at_po;
        logic [64:0] exp2 [4];

        rst_n    = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        force_po = 1'b0;
        {a0, b0, c0, a1, b1, c1} = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_pushin", mul_pushin, 0);
        check("rst_pushout0", pushout0, 0);
        check("rst_pushout1", pushout1, 0);
        check("rst_err", err, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_r0", r0, 0);
        check("rst_r1", r1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single op: 2.0 * 3.0 = 6.0, latency LAT+2 from the grant cycle
        @(posedge clk);
        #1;
        clear_logs();
        req0 = 1'b1;
        a0   = F2P0;
        b0   = F3P0;
        c0   = F1P0;
        @(negedge clk);
        check("t1_gnt0", gnt0, 1);
        check("t1_gnt1", gnt1, 0);
        g = cyc;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        check("t1_pushin", mul_pushin, 1);
        check("t1_mul_a", mul_a, F2P0);
        check("t1_mul_b", mul_b, F3P0);
        check("t1_mul_c", mul_c, F1P0);
        for (int i = 0; i < 40 && ret_log.size() == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("t1_nret", ret_log.size(), 1);
        if (ret_log.size() > 0) begin
            check("t1_latency", ret_cyc[0] - g, LAT + 2);
            check("t1_r0", ret_log[0], {1'b0, F6P0});
        end
        check("t1_err", err, 0);

        // Both requesters held 4 cycles: grants 0,1,0,1 and results follow
        do_reset();
        clear_logs();
        req0 = 1'b1;
        a0   = F2P0;
        b0   = F3P0;
        c0   = '0;
        req1 = 1'b1;
        a1   = F1P5;
        b1   = F2P0;
        c1   = '0;
        repeat (4) @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (LAT + 8) @(negedge clk);
        exp2 = '{{1'b0, F6P0}, {1'b1, F3P0}, {1'b0, F6P0}, {1'b1, F3P0}};
        check("t2_ngnt", gnt_log.size(), 4);
        check("t2_nret", ret_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_log.size()) check($sformatf("t2_gnt%0d", i), gnt_log[i], i % 2);
            if (i < ret_log.size()) check($sformatf("t2_ret%0d", i), ret_log[i], exp2[i]);
        end

        // req0 held with no returns: MAXOUT grants, stall until first pushout0
        do_reset();
        clear_logs();
        req0 = 1'b1;
        a0   = F2P0;
        b0   = F3P0;
        a1   = F1P5;
        b1   = F2P0;
        n0         = 0;
        first_po   = -1;
        gnt0_at_po = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            req1 = (k == 10);
            @(negedge clk);
            if (pushout0 && first_po < 0) begin
                first_po   = k;
                gnt0_at_po = gnt0;
            end else if (gnt0 && first_po < 0) begin
                n0++;
            end
            if (k == 10) begin
                check("t3_gnt1_stall", gnt1, 1);
                check("t3_gnt0_stall", gnt0, 0);
            end
        end
        check("t3_ngrant", n0, MAXOUT);
        check("t3_first_po", first_po, LAT + 2);
        check("t3_gnt0_resume", gnt0_at_po, 1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (LAT + 20) @(negedge clk);

        // Reset with 3 operations in flight
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        clear_logs();
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_cnt0", dut.cnt0_q, 0);
        check("t4_cnt1", dut.cnt1_q, 0);
        repeat (LAT + 10) @(negedge clk);
        check("t4_nret", ret_log.size(), 0);
        @(posedge clk);
        #1;
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        check("t4_gnt0", gnt0, 1);
        check("t4_gnt1", gnt1, 0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (LAT + 8) @(negedge clk);

        // Spurious mul_pushout with an empty tag pipeline
        do_reset();
        clear_logs();
        force_po = 1'b1;
        @(posedge clk);
        #1;
        force_po = 1'b0;
        @(negedge clk);
        check("t5_err_set", err, EXP_ERR);
        repeat (5) @(negedge clk);
        check("t5_err_hold", err, EXP_ERR);
        check("t5_nret", ret_log.size(), 0);
        do_reset();
        @(negedge clk);
        check("t5_err_clr", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
